// File: rtl/mac_col_acc.sv
// -----------------------------------------------------------------------------
// mac_col_acc -- one column of a chained dot-product / accumulate array.
//
// Keys are streamed down the column chain with load beats. This column keeps
// every num_col-th beat, offset by its position, as key slot k. Execute beats
// then multiply the incoming query vector lane-wise by a selected key slot,
// reduce to a partial sum, and accumulate partial sums until a "last" beat
// releases the total on out/out_valid. The query and the instruction fields
// are forwarded two cycles later so the next column sees them in step.
//
// Pipeline: stage 0 registers the inputs, stage 1 forms the lane psum,
// stage 2 accumulates, and the output register presents the result.
// A last beat sampled at edge E therefore raises out_valid after edge E+3.
//
// Build option:
//   MAC_COL_SAT_EN  defined   -> every accumulator addition saturates
//                   undefined -> two's-complement wrap at bw_acc bits
//
// Ports:
//   clk        single clock
//   reset      synchronous, active low
//   q_in       query/key vector, lane i at [i*bw +: bw]
//   i_inst     [1] execute, [0] load (11 = idle)
//   i_kidx     key slot used by an execute beat
//   i_last     last execute beat of an accumulation
//   q_out      q_in delayed two cycles
//   o_inst, o_kidx, o_last   control inputs delayed two cycles
//   out        accumulated result (signed, bw_acc bits), held between pulses
//   out_valid  one-cycle pulse when out is updated
//   load_done  all kd key slots captured
// -----------------------------------------------------------------------------
module mac_col_acc #(
   parameter  int bw       = 8,
   parameter  int pr       = 8,
   parameter  int num_col  = 8,
   parameter  int col_id   = 0,
   parameter  int kd       = 2,
   parameter  int bw_psum  = 2*bw+4,
   parameter  int acc_bits = 4,
   localparam int bw_acc   = bw_psum + acc_bits,
   localparam int kw       = (kd > 1) ? $clog2(kd) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [pr*bw-1:0]          q_in,
   input  logic [1:0]                i_inst,
   input  logic [kw-1:0]             i_kidx,
   input  logic                      i_last,
   output logic [pr*bw-1:0]          q_out,
   output logic [1:0]                o_inst,
   output logic [kw-1:0]             o_kidx,
   output logic                      o_last,
   output logic signed [bw_acc-1:0]  out,
   output logic                      out_valid,
   output logic                      load_done
);

   localparam int cw      = $clog2(kd*num_col + 1);
   localparam int key_off = num_col - 1 - col_id;

   // Accumulator addition: wraps, or clamps to the signed bw_acc range.
   function automatic logic signed [bw_acc-1:0] acc_add(
      input logic signed [bw_acc-1:0] a,
      input logic signed [bw_acc-1:0] b
   );
`ifdef MAC_COL_SAT_EN
      logic signed [bw_acc:0] s;
      s = {a[bw_acc-1], a} + {b[bw_acc-1], b};
      if (s[bw_acc] != s[bw_acc-1]) begin
         acc_add = s[bw_acc] ? {1'b1, {(bw_acc-1){1'b0}}} : {1'b0, {(bw_acc-1){1'b1}}};
      end else begin
         acc_add = s[bw_acc-1:0];
      end
`else
      acc_add = a + b;
`endif
   endfunction

   // stage 0 copies of the inputs
   logic [pr*bw-1:0]          q0_r;
   logic [1:0]                inst0_r;
   logic [kw-1:0]             kidx0_r;
   logic                      last0_r;
   // stage 1 forwarded copies
   logic [pr*bw-1:0]          q1_r;
   logic [1:0]                inst1_r;
   logic [kw-1:0]             kidx1_r;
   logic                      last1_r;
   // execute datapath
   logic                      exec1_r;
   logic                      elast1_r;
   logic signed [bw_psum-1:0] psum1_r;
   logic signed [bw_acc-1:0]  acc_r;
   logic signed [bw_acc-1:0]  res2_r;
   logic                      fire2_r;
   logic signed [bw_acc-1:0]  out_r;
   logic                      out_valid_r;
   // key storage and load tracking
   logic [pr*bw-1:0]          key_r [kd];
   logic [cw-1:0]             n_r;
   logic                      done_r;

   logic                      is_load_s;
   logic                      is_exec_s;
   logic [kw-1:0]             sel_s;
   logic [pr*bw-1:0]          key_sel_s;
   logic [bw-1:0]             qa_s;
   logic [bw-1:0]             kb_s;
   logic [2*bw-1:0]           prod_s;
   logic signed [bw_psum-1:0] psum_s;
   logic [kd-1:0]             hit_s;
   logic signed [bw_acc-1:0]  psum_acc_s;
   logic signed [bw_acc-1:0]  sum2_s;

   assign is_load_s  = (inst0_r == 2'b01);
   assign is_exec_s  = (inst0_r == 2'b10);
   assign psum_acc_s = {{acc_bits{psum1_r[bw_psum-1]}}, psum1_r};
   assign sum2_s     = acc_add(acc_r, psum_acc_s);

   // Key slot select (out-of-range index clamps to the top slot) and lane dot product.
   always_comb begin
      qa_s   = '0;
      kb_s   = '0;
      prod_s = '0;
      psum_s = '0;
      if (int'(kidx0_r) >= kd) begin
         sel_s = kw'(kd-1);
      end else begin
         sel_s = kidx0_r;
      end
      key_sel_s = key_r[sel_s];
      for (int i = 0; i < pr; i++) begin
         qa_s   = q0_r[i*bw +: bw];
         kb_s   = key_sel_s[i*bw +: bw];
         // low 2*bw bits of the sign-extended product are the signed product
         prod_s = {{bw{qa_s[bw-1]}}, qa_s} * {{bw{kb_s[bw-1]}}, kb_s};
         psum_s = psum_s + {{(bw_psum-2*bw){prod_s[2*bw-1]}}, prod_s};
      end
   end

   // Which key slot, if any, the current load-beat count lands on.
   always_comb begin
      hit_s = '0;
      for (int k = 0; k < kd; k++) begin
         hit_s[k] = (int'(n_r) == k*num_col + key_off);
      end
   end

   // Stage 0 input capture and stage 1 forwarding registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q0_r    <= '0;
         inst0_r <= 2'b00;
         kidx0_r <= '0;
         last0_r <= 1'b0;
         q1_r    <= '0;
         inst1_r <= 2'b00;
         kidx1_r <= '0;
         last1_r <= 1'b0;
      end else begin
         q0_r    <= q_in;
         inst0_r <= i_inst;
         kidx0_r <= i_kidx;
         last0_r <= i_last;
         q1_r    <= q0_r;
         inst1_r <= inst0_r;
         kidx1_r <= kidx0_r;
         last1_r <= last0_r;
      end
   end

   // Load-beat counting and key capture; frozen once every slot is filled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         n_r    <= '0;
         done_r <= 1'b0;
         for (int k = 0; k < kd; k++) begin
            key_r[k] <= '0;
         end
      end else if (is_load_s && !done_r) begin
         n_r <= n_r + cw'(1);
         for (int k = 0; k < kd; k++) begin
            if (hit_s[k]) begin
               key_r[k] <= q0_r;
            end
         end
         if (hit_s[kd-1]) begin
            done_r <= 1'b1;
         end
      end
   end

   // Execute pipeline: psum, accumulate, and release on the last beat.
   always_ff @(posedge clk) begin
      if (!reset) begin
         exec1_r     <= 1'b0;
         elast1_r    <= 1'b0;
         psum1_r     <= '0;
         acc_r       <= '0;
         res2_r      <= '0;
         fire2_r     <= 1'b0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end else begin
         exec1_r  <= is_exec_s;
         elast1_r <= is_exec_s & last0_r;
         psum1_r  <= psum_s;
         if (exec1_r && elast1_r) begin
            res2_r  <= sum2_s;
            fire2_r <= 1'b1;
            acc_r   <= '0;
         end else if (exec1_r) begin
            acc_r   <= sum2_s;
            fire2_r <= 1'b0;
         end else begin
            fire2_r <= 1'b0;
         end
         out_valid_r <= fire2_r;
         if (fire2_r) begin
            out_r <= res2_r;
         end
      end
   end

   assign q_out     = q1_r;
   assign o_inst    = inst1_r;
   assign o_kidx    = kidx1_r;
   assign o_last    = last1_r;
   assign out       = out_r;
   assign out_valid = out_valid_r;
   assign load_done = done_r;

endmodule

// File: tb/tb_mac_col_acc.sv
module tb_mac_col_acc;

   localparam int NC  = 8;
   localparam int CID = 0;
   localparam int KD  = 2;
   localparam int PR  = 8;
   localparam int OFF = NC - 1 - CID;
   localparam int HN  = 8192;

   logic               clk;
   logic               reset;
   logic [63:0]        q_in;
   logic [1:0]         i_inst;
   logic               i_kidx;
   logic               i_last;
   logic [63:0]        q_out;
   logic [1:0]         o_inst;
   logic               o_kidx;
   logic               o_last;
   logic signed [23:0] out;
   logic               out_valid;
   logic               load_done;

   mac_col_acc dut (
      .clk(clk), .reset(reset), .q_in(q_in), .i_inst(i_inst), .i_kidx(i_kidx),
      .i_last(i_last), .q_out(q_out), .o_inst(o_inst), .o_kidx(o_kidx),
      .o_last(o_last), .out(out), .out_valid(out_valid), .load_done(load_done)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   // reference model state
   longint mkey [KD][PR];
   int     mn;
   bit     mdone;
   longint macc;
   longint exp_out;
   // per-edge history of what was sampled and what the model predicts
   logic [63:0] q_h    [HN];
   logic [3:0]  ctl_h  [HN];
   bit          fire_h [HN];
   longint      res_h  [HN];
   bit          done_h [HN];
   int          c;

   typedef struct {
      logic [7:0] lane;
      logic [1:0] inst;
      logic       kidx;
      logic       last;
      bit         ev;
      longint     eo;
      bit         ed;
   } vec_t;
   vec_t tbl [26];

   function automatic longint lane(input logic [63:0] q, input int i);
      logic signed [7:0] b;
      b = q[i*8 +: 8];
      return longint'(b);
   endfunction

   function automatic longint fold(input longint v);
`ifdef MAC_COL_SAT_EN
      if (v > 64'sd8388607) return 64'sd8388607;
      else if (v < -64'sd8388608) return -64'sd8388608;
      else return v;
`else
      longint w;
      w = v & 64'sh0000_0000_00FF_FFFF;
      if (w >= 64'sd8388608) w = w - 64'sd16777216;
      return w;
`endif
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, c, act, exp);
      end
   endtask

   task automatic model_beat(input logic [63:0] q, input logic [1:0] inst, input logic k, input logic l);
      longint p;
      int slot;
      q_h[c]    = q;
      ctl_h[c]  = {inst, k, l};
      fire_h[c] = 1'b0;
      res_h[c]  = 0;
      if (inst == 2'b01 && !mdone) begin
         if (mn >= OFF && (mn - OFF) % NC == 0 && (mn - OFF) / NC < KD) begin
            slot = (mn - OFF) / NC;
            for (int i = 0; i < PR; i++) mkey[slot][i] = lane(q, i);
            if (slot == KD - 1) mdone = 1'b1;
         end
         mn++;
      end else if (inst == 2'b10) begin
         p = 0;
         for (int i = 0; i < PR; i++) p += lane(q, i) * mkey[(int'(k) >= KD) ? KD-1 : int'(k)][i];
         if (l) begin
            res_h[c]  = fold(macc + p);
            fire_h[c] = 1'b1;
            macc      = 0;
         end else begin
            macc = fold(macc + p);
         end
      end
      done_h[c] = mdone;
   endtask

   task automatic step(input logic [63:0] q, input logic [1:0] inst, input logic k, input logic l);
      q_in = q; i_inst = inst; i_kidx = k; i_last = l;
      @(posedge clk);
      #1;
      model_beat(q, inst, k, l);
      if (c >= 3 && fire_h[c-3]) exp_out = res_h[c-3];
      chk("out_valid", 64'(out_valid), (c >= 3) ? 64'(fire_h[c-3]) : 64'd0);
      chk("out", 64'(longint'(out)), 64'(exp_out));
      chk("q_out", q_out, (c >= 1) ? q_h[c-1] : 64'd0);
      chk("o_ctl", 64'({o_inst, o_kidx, o_last}), (c >= 1) ? 64'(ctl_h[c-1]) : 64'd0);
      chk("load_done", 64'(load_done), (c >= 1) ? 64'(done_h[c-1]) : 64'd0);
      c++;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      q_in = {$urandom, $urandom}; i_inst = 2'($urandom); i_kidx = 1'($urandom); i_last = 1'($urandom);
      @(posedge clk);
      #1;
      q_h[c] = '0; ctl_h[c] = '0; fire_h[c] = 1'b0; res_h[c] = 0; done_h[c] = 1'b0;
      if (c >= 1) fire_h[c-1] = 1'b0;
      if (c >= 2) fire_h[c-2] = 1'b0;
      for (int s = 0; s < KD; s++) for (int i = 0; i < PR; i++) mkey[s][i] = 0;
      mn = 0; mdone = 1'b0; macc = 0; exp_out = 0;
      chk("rst_out", 64'(longint'(out)), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_done", 64'(load_done), 64'd0);
      chk("rst_fwd", q_out ^ 64'({o_inst, o_kidx, o_last}), 64'd0);
      c++;
      reset = 1'b1;
   endtask

   task automatic load_all(input bit rnd, input logic [7:0] v);
      for (int n = 0; n < NC*KD; n++) begin
         if (rnd) step({$urandom, $urandom}, 2'b01, 1'b0, 1'b0);
         else     step({8{v}}, 2'b01, 1'b0, 1'b0);
      end
   endtask

   initial begin
      longint ovf_exp;
      clk = 1'b0; reset = 1'b0; c = 0;
      q_in = '0; i_inst = 2'b00; i_kidx = 1'b0; i_last = 1'b0;
      do_reset();
      do_reset();

      // directed table: key capture, single execute, accumulation with idle gap
      for (int i = 0; i < 26; i++) begin
         tbl[i].kidx = 1'b0; tbl[i].last = 1'b0; tbl[i].lane = 8'd0; tbl[i].inst = 2'b00;
         tbl[i].ev   = (i == 20) || (i == 24);
         tbl[i].eo   = (i >= 24) ? 64'sd720 : (i >= 20) ? 64'sd56 : 64'sd0;
         tbl[i].ed   = (i >= 16);
         if (i < 16) begin tbl[i].lane = 8'(i); tbl[i].inst = 2'b01; end
      end
      tbl[16].lane = 8'd99; tbl[16].inst = 2'b01;
      tbl[17].lane = 8'd1;  tbl[17].inst = 2'b10; tbl[17].last = 1'b1;
      tbl[18].lane = 8'd2;  tbl[18].inst = 2'b10; tbl[18].kidx = 1'b1;
      tbl[19].lane = 8'd55; tbl[19].inst = 2'b11; tbl[19].kidx = 1'b1; tbl[19].last = 1'b1;
      tbl[20].lane = 8'd2;  tbl[20].inst = 2'b10; tbl[20].kidx = 1'b1;
      tbl[21].lane = 8'd2;  tbl[21].inst = 2'b10; tbl[21].kidx = 1'b1; tbl[21].last = 1'b1;
      for (int i = 0; i < 26; i++) begin
         step({8{tbl[i].lane}}, tbl[i].inst, tbl[i].kidx, tbl[i].last);
         chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
         chk("tbl_out", 64'(longint'(out)), 64'(tbl[i].eo));
         chk("tbl_done", 64'(load_done), 64'(tbl[i].ed));
      end

      // overflow: 64 beats of (-128)*(-128) over 8 lanes reach exactly 2^23
      do_reset();
      load_all(1'b0, 8'h80);
      for (int b = 0; b < 64; b++) step({8{8'h80}}, 2'b10, 1'b0, (b == 63));
      for (int b = 0; b < 3; b++) step('0, 2'b00, 1'b0, 1'b0);
`ifdef MAC_COL_SAT_EN
      ovf_exp = 64'sd8388607;
`else
      ovf_exp = -64'sd8388608;
`endif
      chk("ovf_valid", 64'(out_valid), 64'd1);
      chk("ovf_out", 64'(longint'(out)), 64'(ovf_exp));

      // reset in the middle of an accumulation, then a fresh load and run
      do_reset();
      load_all(1'b1, 8'd0);
      step({$urandom, $urandom}, 2'b10, 1'b0, 1'b0);
      step({$urandom, $urandom}, 2'b10, 1'b1, 1'b0);
      do_reset();
      for (int b = 0; b < 5; b++) step('0, 2'b00, 1'b0, 1'b0);
      chk("midrst_out", 64'(longint'(out)), 64'd0);
      load_all(1'b1, 8'd0);
      for (int b = 0; b < 3; b++) step({$urandom, $urandom}, 2'b10, 1'($urandom), (b == 2));
      for (int b = 0; b < 4; b++) step('0, 2'b00, 1'b0, 1'b0);

      // randomized traffic against the model
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else step({$urandom, $urandom}, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      end
      for (int b = 0; b < 4; b++) step('0, 2'b00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/mac_col_acc.md
MAC_COL_ACC -- requirements
Module: mac_col_acc

Interface
REQ-001 SHALL have parameter bw, default 8, meaning signed element width.
REQ-002 SHALL have parameter pr, default 8, meaning elements per vector (lanes).
REQ-003 SHALL have parameter num_col, default 8, meaning number of columns in the chain.
REQ-004 SHALL have parameter col_id, default 0, meaning this column's index (0..num_col-1).
REQ-005 SHALL have parameter kd, default 2, meaning key slots stored per column.
REQ-006 SHALL have parameters bw_psum, default 2*bw+4, and acc_bits, default 4; bw_acc = bw_psum+acc_bits.
REQ-007 SHALL have port clk, input, 1, meaning the single clock.
REQ-008 SHALL have port reset, input, 1, meaning synchronous active-low reset (asserted at 0).
REQ-009 SHALL have port q_in, input, pr*bw, meaning query/key vector; lane i is at bits [i*bw +: bw].
REQ-010 SHALL have port i_inst, input, 2, meaning [1] execute and [0] load.
REQ-011 SHALL have port i_kidx, input, max(1,clog2(kd)), meaning the key slot for execute.
REQ-012 SHALL have port i_last, input, 1, meaning the last execute beat of an accumulation.
REQ-013 SHALL have port q_out, output, pr*bw, meaning q_in delayed two cycles.
REQ-014 SHALL have ports o_inst, o_kidx and o_last, outputs, widths matching their inputs, meaning the corresponding inputs delayed two cycles.
REQ-015 SHALL have port out, output signed, bw_acc, meaning the accumulated result.
REQ-016 SHALL have port out_valid, output, 1, meaning a one-cycle pulse when out is updated.
REQ-017 SHALL have port load_done, output, 1, meaning all kd key slots are captured.

Function
REQ-018 SHALL register all inputs in stage 0; all decode uses the stage-0 copies.
- i_inst=11 SHALL be treated as idle.
REQ-019 SHALL count each load beat with a load-beat counter n, starting at 0.
- Beat n = k*num_col + (num_col-1-col_id), for k < kd, SHALL be captured into key slot k.
REQ-020 SHALL set load_done after slot kd-1 is captured; once set, load beats are ignored and the counter is frozen.
REQ-021 SHALL, on an execute beat, compute in stage 1 the sum over lanes of query*key[kidx] at full bw_psum signed width, registered.
- A kidx of kd or more SHALL select slot kd-1.
REQ-022 SHALL, in stage 2, add the stage-1 psum to the accumulator acc.
REQ-023 SHALL, when the beat is last, load out with acc+psum, pulse out_valid, and clear acc to 0.
REQ-024 SHALL make latency exactly 3 edges: last execute beat sampled at edge E means out_valid is high during the cycle after edge E+3.
REQ-025 SHALL hold acc through idle and load cycles between execute beats; accumulation resumes on the next execute beat.
REQ-026 SHALL hold out between pulses.
REQ-027 SHALL, during back-to-back last beats, produce one out_valid pulse per beat with no bubble.
REQ-028 SHALL forward q_out, o_inst, o_kidx and o_last every cycle regardless of instruction.
REQ-029 SHALL wrap the accumulator in two's complement at bw_acc when MAC_COL_SAT_EN is undefined.

Reset
REQ-030 SHALL, while reset=0 at a clock edge, clear out, acc, psum, key slots, load counter, load_done, out_valid, q_out, o_inst, o_kidx, o_last and all pipeline registers to 0.
REQ-031 SHALL discard any in-flight accumulation on reset mid-operation: no out_valid is produced for it, and load must be repeated.

Configuration
REQ-032 SHALL, with macro MAC_COL_SAT_EN defined, saturate acc+psum to [-2^(bw_acc-1), 2^(bw_acc-1)-1] on every addition, including the output sum.
- Without the macro, arithmetic SHALL wrap (REQ-029).

Verification (bw=8, pr=8, num_col=8, col_id=0, kd=2)
REQ-033 Load, key capture: load 16 beats, beat n with all lanes=n -> slot0 holds all 7, slot1 holds all 15, load_done=1 after beat 15; 17th load beat leaves keys unchanged.
REQ-034 Single execute: query all lanes=1, kidx=0, last=1 -> out=56 with out_valid one cycle, 3 edges later.
REQ-035 Accumulation: 3 beats of query all lanes=2, kidx=1, last on 3rd, idle cycle between beats 1 and 2 -> single pulse with out=720.
REQ-036 Overflow: 64 beats of query all lanes=-128, keys all -128, last on 64th -> out=8388607 with MAC_COL_SAT_EN defined, -8388608 without.
REQ-037 Reset mid-accumulation: reset=0 after 2 of 3 beats -> no out_valid and out=0; a fresh load and execute then produce the correct result.
REQ-038 Idle instruction: i_inst=11 -> no key capture, no acc change, forwarded o_inst=11 two cycles later.
